// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment display path:
// active-low glyph table, blanking constants and the digit index type.
package sevenseg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [6:0] GLYPHS [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-glyph decoder for active-low seven-segment displays.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPHS[nibble_i];

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver: refresh prescaler, digit scan,
// once-per-frame shadow capture and registered anode/segment outputs.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int              CNT_W    = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [15:0]      sh_value_q, sh_value_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic [3:0]       sh_en_q, sh_en_d;
  logic             sh_lz_q, sh_lz_d;
  logic             frame_done_q, frame_done_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick_s;
  logic             load_s;
  logic [3:0]       nibble_s;
  logic [6:0]       glyph_s;
  logic [3:0]       nz_s;
  logic             lz_blank_s;
  logic             dark_s;

  assign tick_s = (cnt_q == CNT_LAST);
  assign load_s = tick_s && (idx_q == 2'd3);

  // Prescaler, digit index and frame shadow next-state.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sh_value_d   = sh_value_q;
    sh_dp_d      = sh_dp_q;
    sh_en_d      = sh_en_q;
    sh_lz_d      = sh_lz_q;
    frame_done_d = load_s;
    if (tick_s) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load_s) begin
      sh_value_d = value;
      sh_dp_d    = dp_in;
      sh_en_d    = digit_en;
      sh_lz_d    = blank_lz;
    end else begin
      sh_value_d = sh_value_q;
    end
  end

  always_comb begin
    nz_s = {|sh_value_q[15:12], |sh_value_q[11:8], |sh_value_q[7:4], |sh_value_q[3:0]};
  end

  // Current nibble and leading-zero blanking; digit 0 always shows.
  always_comb begin
    nibble_s   = 4'h0;
    lz_blank_s = 1'b0;
    case (idx_q)
      2'd0: begin nibble_s = sh_value_q[3:0];   lz_blank_s = 1'b0;                          end
      2'd1: begin nibble_s = sh_value_q[7:4];   lz_blank_s = ~(nz_s[3] | nz_s[2] | nz_s[1]); end
      2'd2: begin nibble_s = sh_value_q[11:8];  lz_blank_s = ~(nz_s[3] | nz_s[2]);           end
      2'd3: begin nibble_s = sh_value_q[15:12]; lz_blank_s = ~nz_s[3];                       end
      default: begin nibble_s = 4'h0;           lz_blank_s = 1'b0;                          end
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble_i (nibble_s),
    .seg_o    (glyph_s)
  );

  assign dark_s = ~sh_en_q[idx_q] | (sh_lz_q & lz_blank_s);

  // Next anode/segment/dp drive for the digit currently indexed.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (dark_s) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = glyph_s;
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  // State and output registers; reset forces the display dark at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      sh_value_q   <= 16'h0000;
      sh_dp_q      <= 4'b0000;
      sh_en_q      <= 4'b0000;
      sh_lz_q      <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_value_q   <= sh_value_d;
      sh_dp_q      <= sh_dp_d;
      sh_en_q      <= sh_en_d;
      sh_lz_q      <= sh_lz_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: one instance at REFRESH_DIV=4 and one at
// REFRESH_DIV=1 sharing clock, reset and data inputs.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  digit_en = 4'b0000;
  logic        blank_lz = 1'b0;

  logic [3:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       dp4, dp1, fd4, fd1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .blank_lz(blank_lz), .an(an4), .seg(seg4), .dp(dp4), .frame_done(fd4)
  );

  sevenseg_scan #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .blank_lz(blank_lz), .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
  );

  task automatic wait_fd(input bit use_min, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if ((use_min ? fd1 : fd4) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if ({an4, seg4, dp4, fd4} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_div4: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0", an4, seg4, dp4, fd4);
    end
    n_tests++;
    if ({an1, seg1, dp1, fd1} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_div1: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0", an1, seg1, dp1, fd1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_full_hex;
    logic [11:0] exp_tbl [0:3];
    logic [12:0] want;
    bit ok;
    exp_tbl = '{{4'b1110, 7'b0001110, 1'b1}, {4'b1101, 7'b0001000, 1'b1},
                {4'b1011, 7'b0100100, 1'b1}, {4'b0111, 7'b1111001, 1'b1}};
    value = 16'h12AF; dp_in = 4'b0000; digit_en = 4'b1111; blank_lz = 1'b0;
    wait_fd(1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL full_hex_timeout: got no frame_done want pulse"); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      want = {exp_tbl[i / 4], (i == 15)};
      n_tests++;
      if ({an4, seg4, dp4, fd4} !== want) begin
        n_fail++;
        $display("FAIL full_hex[%0d]: got %b want %b", i, {an4, seg4, dp4, fd4}, want);
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [15:0] vals [0:2];
    logic [10:0] exp_tbl [0:11];
    bit ok;
    vals = '{16'h0005, 16'h0000, 16'h0105};
    exp_tbl = '{{4'b1110, 7'b0010010}, {4'b1111, 7'b1111111}, {4'b1111, 7'b1111111}, {4'b1111, 7'b1111111},
                {4'b1110, 7'b1000000}, {4'b1111, 7'b1111111}, {4'b1111, 7'b1111111}, {4'b1111, 7'b1111111},
                {4'b1110, 7'b0010010}, {4'b1101, 7'b1000000}, {4'b1011, 7'b1111001}, {4'b1111, 7'b1111111}};
    blank_lz = 1'b1; digit_en = 4'b1111; dp_in = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      value = vals[c];
      wait_fd(1'b0, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL lz_timeout[%0d]: got no frame_done want pulse", c); end
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        n_tests++;
        if ({an4, seg4, dp4} !== {exp_tbl[c * 4 + i / 4], 1'b1}) begin
          n_fail++;
          $display("FAIL lz_%h[%0d]: got %b want %b", vals[c], i, {an4, seg4, dp4}, {exp_tbl[c * 4 + i / 4], 1'b1});
        end
      end
    end
  endtask

  task automatic test_shadow_timing;
    logic [10:0] old_tbl [0:3];
    logic [10:0] new_tbl [0:3];
    logic [11:0] want;
    bit ok;
    old_tbl = '{{4'b1110, 7'b0001110}, {4'b1101, 7'b0001000}, {4'b1011, 7'b0100100}, {4'b0111, 7'b1111001}};
    new_tbl = '{{4'b1110, 7'b0000010}, {4'b1101, 7'b0010010}, {4'b1011, 7'b0011001}, {4'b0111, 7'b0110000}};
    value = 16'h12AF; blank_lz = 1'b0; digit_en = 4'b1111; dp_in = 4'b0000;
    wait_fd(1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL shadow_timeout: got no frame_done want pulse"); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      want = {(i < 16) ? old_tbl[i / 4] : new_tbl[(i - 16) / 4], (i % 16 == 15)};
      n_tests++;
      if ({an4, seg4, fd4} !== want) begin
        n_fail++;
        $display("FAIL shadow[%0d]: got %b want %b", i, {an4, seg4, fd4}, want);
      end
      if (i == 5) value = 16'h3456;
    end
  endtask

  task automatic test_dp_enable;
    logic [11:0] exp_tbl [0:3];
    bit ok;
    exp_tbl = '{{4'b1110, 7'b0001110, 1'b1}, {4'b1101, 7'b0001000, 1'b1},
                {4'b1011, 7'b0100100, 1'b0}, {4'b1111, 7'b1111111, 1'b1}};
    value = 16'h12AF; blank_lz = 1'b0; dp_in = 4'b0100; digit_en = 4'b0111;
    wait_fd(1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL dp_en_timeout: got no frame_done want pulse"); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_tests++;
      if ({an4, seg4, dp4} !== exp_tbl[i / 4]) begin
        n_fail++;
        $display("FAIL dp_en[%0d]: got %b want %b", i, {an4, seg4, dp4}, exp_tbl[i / 4]);
      end
    end
  endtask

  task automatic test_min_div;
    logic [10:0] exp_tbl [0:3];
    logic [11:0] want;
    bit ok;
    exp_tbl = '{{4'b1110, 7'b0001110}, {4'b1101, 7'b0001000}, {4'b1011, 7'b0100100}, {4'b0111, 7'b1111001}};
    value = 16'h12AF; blank_lz = 1'b0; dp_in = 4'b0000; digit_en = 4'b1111;
    wait_fd(1'b1, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL min_div_timeout: got no frame_done want pulse"); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      want = {exp_tbl[i % 4], (i % 4 == 3)};
      n_tests++;
      if ({an1, seg1, fd1} !== want) begin
        n_fail++;
        $display("FAIL min_div[%0d]: got %b want %b", i, {an1, seg1, fd1}, want);
      end
    end
  endtask

  task automatic test_reset_mid;
    int  fd_at;
    bit  dark_ok;
    value = 16'h12AF; blank_lz = 1'b0; dp_in = 4'b0000; digit_en = 4'b1111;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({an4, seg4, dp4} !== {4'b1111, 7'b1111111, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_dark: got %b want 111111111111", {an4, seg4, dp4});
    end
    @(negedge clk);
    rst = 1'b1;
    fd_at = 0;
    dark_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (fd4 === 1'b1) begin
        fd_at = i;
        break;
      end
      if (an4 !== 4'b1111) dark_ok = 1'b0;
    end
    n_tests++;
    if (fd_at != 16) begin n_fail++; $display("FAIL reset_mid_first_frame: got %0d want 16", fd_at); end
    n_tests++;
    if (dark_ok !== 1'b1) begin n_fail++; $display("FAIL reset_mid_first_dark: got lit digit want dark"); end
    @(negedge clk);
    n_tests++;
    if ({an4, seg4} !== {4'b1110, 7'b0001110}) begin
      n_fail++;
      $display("FAIL reset_mid_first_lit: got %b want 11100001110", {an4, seg4});
    end
  endtask

  initial begin
    test_reset();
    test_full_hex();
    test_leading_zero();
    test_shadow_timing();
    test_dp_enable();
    test_min_div();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Time-multiplexed driver for the four-digit, common-anode seven-segment display on the Basys 3.
- Sits downstream of the clock-divider/prescaler stage and consumes the calculator's 16-bit result.
- Runs on the single system clock with an internal refresh prescaler; produces no derived clocks.
- Scans one digit per refresh tick.
- Latches display data once per frame so a value changing mid-scan never shows a mixed frame.

Parameters:
- REFRESH_DIV, 100000: system-clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- value  input  16  four hex nibbles; nibble k drives digit k (digit 0 is rightmost).
- dp_in  input  4  decimal point request per digit, active-high.
- digit_en  input  4  per-digit enable; 0 forces the digit dark.
- blank_lz  input  1  1 = suppress leading zeros.
- an  output  4  anode selects, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point segment, active-low.
- frame_done  output  1  one-cycle pulse when shadow registers load.

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, idx=0, shadow value/dp/en/lz=0, an=4'b1111, seg=7'b1111111, dp=1, frame_done=0. Outputs go dark immediately, with no clock required.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0; width $clog2(REFRESH_DIV+1).
  - tick = (cnt==REFRESH_DIV-1). With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index: on a tick edge, idx advances 0→1→2→3→0 (2-bit wrap).
- Shadow load:
  - On the tick edge where idx==3, capture value, dp_in, digit_en and blank_lz into shadow registers.
  - Assert frame_done for exactly that one following cycle.
  - Between loads, input changes have no effect on outputs.
  - After reset, the shadow holds zeros until the first frame completes. Shadow digit_en=0 means the display stays dark for the first frame.
- Output stage:
  - an/seg/dp are registered from (idx, shadow), so they reflect a new idx one cycle after idx changes.
  - Each digit is held for exactly REFRESH_DIV cycles in steady state.
  - Exactly one an bit is low at a time, or none when the current digit is dark.
- Digit dark condition: shadow_en[idx]==0, OR leading-zero blank.
  - When dark: an=4'b1111, seg=7'b1111111, dp=1.
- Leading-zero rule (shadow_lz=1):
  - Digit k (k=3..1) is blank when nibble k and every higher nibble are 0.
  - Digit 0 is never blanked by this rule, so 0x0000 shows a single "0".
- Lit digit: an = ~(4'b0001<<idx); seg = hex glyph of nibble idx; dp = ~shadow_dp[idx].
- Glyphs, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-scan: immediate dark outputs. After release, scan restarts at digit 0 with cnt=0.
- No ghosting guard: the anode and segment changes land on the same edge.

Decomposition:
- Shared package sevenseg_pkg:
  - 16-entry glyph constant table.
  - SEG_OFF=7'b1111111 and AN_OFF=4'b1111 constants.
  - Digit index typedef (2-bit).
- Natural sub-module: hex_to_7seg, a combinational nibble→glyph decoder using the package table, reusable by other display paths.
- Prescaler, idx, shadow registers and output registers stay in sevenseg_scan.

Test Plan (REFRESH_DIV=4 unless noted):
1. Reset handling:
   - Drive rst=0 mid-scan → an=1111, seg=1111111, dp=1 in the same cycle with no clock edge.
   - Release → first lit slot is digit 0.
2. Full hex frame: value=16'h12AF, digit_en=1111, blank_lz=0; after one frame_done, the slots cycle:
   - an=1110 seg=0001110
   - an=1101 seg=0001000
   - an=1011 seg=0100100
   - an=0111 seg=1111001
   - Each slot held exactly 4 cycles.
3. Leading-zero blanking, blank_lz=1:
   - value=16'h0005 → digits 1–3 slots an=1111; digit 0 slot an=1110 seg=0010010.
   - value=16'h0000 → digit 0 shows 1000000.
   - value=16'h0105 → digit 1 shows 1000000 and digit 3 is dark.
4. Shadow timing:
   - Change value during the digit-1 slot → displayed glyphs unchanged until the cycle after the next frame_done.
   - frame_done is high for 1 cycle every 16 cycles.
5. dp and enable: dp_in=4'b0100, digit_en=4'b0111 → dp=0 only during the digit-2 slot; digit-3 slot fully dark (an=1111).
6. Minimum divider: REFRESH_DIV=1 → idx advances every cycle, frame_done every 4 cycles, an sequence 1110,1101,1011,0111 repeating.
